// File: rtl/traffic_cmd_scheduler.sv
// traffic_cmd_scheduler: sole driver of the traffic light command bus.
// Issues the power-on configuration sequence (green, red, yellow timing,
// then normal mode), then round-robins the bus among REQ_N requesters with
// a one-cycle accept pulse and a CMD_GAP idle window after every command.
// Optional build macro TRAFFIC_CMD_PRIO_EN: requester 0 gets strict
// priority and may pre-empt the init sequence with an "off" (type 1) command.
//
// state     | meaning
// ----------+---------------------------------------------------------
// INIT_G_S  | issue green time (type 3, GREEN_MS_DEF)
// INIT_R_S  | issue red time (type 4, RED_MS_DEF)
// INIT_Y_S  | issue yellow time (type 5, YELLOW_MS_DEF)
// INIT_ON_S | issue normal mode (type 0, data 0)
// ARB_S     | sample requests, grant one round-robin winner
// GAP_S     | count CMD_GAP idle cycles, then resume at ret_q
module traffic_cmd_scheduler #(
    parameter int          REQ_N         = 4,
    parameter logic [15:0] GREEN_MS_DEF  = 16'd1000,
    parameter logic [15:0] RED_MS_DEF    = 16'd1000,
    parameter logic [15:0] YELLOW_MS_DEF = 16'd300,
    parameter int          CMD_GAP       = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REQ_N-1:0]     req_valid_i,
    input  logic [3*REQ_N-1:0]   req_type_i,
    input  logic [16*REQ_N-1:0]  req_data_i,
    output logic [REQ_N-1:0]     req_ready_o,
    output logic [2:0]           cmd_type_o,
    output logic [15:0]          cmd_data_o,
    output logic                 cmd_valid_o,
    output logic [2:0]           grant_id_o,
    output logic                 drop_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CMD_GAP + 1);

    typedef enum logic [2:0] {
        INIT_G_S,
        INIT_R_S,
        INIT_Y_S,
        INIT_ON_S,
        ARB_S,
        GAP_S
    } state_t;

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [REQ_N-1:0]   req_ready_q, req_ready_d;
    logic [2:0]         cmd_type_q, cmd_type_d;
    logic [15:0]        cmd_data_q, cmd_data_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic               drop_q, drop_d;
    logic               busy_q, busy_d;

    logic               win_found;
    int                 win_idx;
    int                 cand;
    logic [2:0]         sel_type;
    logic [15:0]        sel_data;
    logic               prio_init;
    logic [2:0]         init_type;
    logic [15:0]        init_data;
    state_t             init_next;

    // Pick the winner: first valid requester after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        cand      = 0;
        sel_type  = 3'd0;
        sel_data  = 16'd0;
`ifdef TRAFFIC_CMD_PRIO_EN
        if (req_valid_i[0]) begin
            win_found = 1'b1;
            win_idx   = 0;
        end
        prio_init = req_valid_i[0] && (req_type_i[2:0] == 3'd1);
`else
        prio_init = 1'b0;
`endif
        for (int off = 1; off <= REQ_N; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= REQ_N) begin
                cand = cand - REQ_N;
            end
            for (int j = 0; j < REQ_N; j++) begin
                if (!win_found && (j == cand) && req_valid_i[j]) begin
                    win_found = 1'b1;
                    win_idx   = j;
                end
            end
        end
        for (int j = 0; j < REQ_N; j++) begin
            if (j == win_idx) begin
                sel_type = req_type_i[3*j +: 3];
                sel_data = req_data_i[16*j +: 16];
            end
        end
    end

    // Fixed init command table, indexed by the current INIT state.
    always_comb begin
        init_type = 3'd0;
        init_data = 16'd0;
        init_next = ARB_S;
        case (state_q)
            INIT_G_S: begin
                init_type = 3'd3;
                init_data = GREEN_MS_DEF;
                init_next = INIT_R_S;
            end
            INIT_R_S: begin
                init_type = 3'd4;
                init_data = RED_MS_DEF;
                init_next = INIT_Y_S;
            end
            INIT_Y_S: begin
                init_type = 3'd5;
                init_data = YELLOW_MS_DEF;
                init_next = INIT_ON_S;
            end
            default: begin
                init_type = 3'd0;
                init_data = 16'd0;
                init_next = ARB_S;
            end
        endcase
    end

    // Next-state and next-output logic; strobes default low, fields hold.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        req_ready_d = '0;
        cmd_type_d  = cmd_type_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        grant_id_d  = grant_id_q;
        drop_d      = 1'b0;
        case (state_q)
            INIT_G_S, INIT_R_S, INIT_Y_S, INIT_ON_S: begin
                if (prio_init) begin
                    // Pre-empting "off" from requester 0; init resumes here.
                    req_ready_d[0] = 1'b1;
                    cmd_valid_d    = 1'b1;
                    cmd_type_d     = 3'd1;
                    cmd_data_d     = req_data_i[15:0];
                    grant_id_d     = 3'd0;
                    ret_d          = state_q;
                end else begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = init_type;
                    cmd_data_d  = init_data;
                    ret_d       = init_next;
                end
                cnt_d   = CNT_W'(CMD_GAP);
                state_d = GAP_S;
            end
            ARB_S: begin
                if (win_found) begin
                    for (int j = 0; j < REQ_N; j++) begin
                        if (j == win_idx) begin
                            req_ready_d[j] = 1'b1;
                        end
                    end
                    grant_id_d = 3'(win_idx);
                    if (sel_type >= 3'd6) begin
                        drop_d = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_type_d  = sel_type;
                        cmd_data_d  = sel_data;
                    end
`ifdef TRAFFIC_CMD_PRIO_EN
                    if (win_idx != 0) begin
                        ptr_d = 3'(win_idx);
                    end
`else
                    ptr_d = 3'(win_idx);
`endif
                    ret_d   = ARB_S;
                    cnt_d   = CNT_W'(CMD_GAP);
                    state_d = GAP_S;
                end
            end
            GAP_S: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ret_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = INIT_G_S;
            end
        endcase
        busy_d = (state_d != ARB_S);
    end

    // State and registered outputs; reset restarts the init sequence.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= INIT_G_S;
            ret_q       <= INIT_G_S;
            cnt_q       <= '0;
            ptr_q       <= 3'(REQ_N - 1);
            req_ready_q <= '0;
            cmd_type_q  <= 3'd0;
            cmd_data_q  <= 16'd0;
            cmd_valid_q <= 1'b0;
            grant_id_q  <= 3'd0;
            drop_q      <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            req_ready_q <= req_ready_d;
            cmd_type_q  <= cmd_type_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            grant_id_q  <= grant_id_d;
            drop_q      <= drop_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign cmd_type_o  = cmd_type_q;
    assign cmd_data_o  = cmd_data_q;
    assign cmd_valid_o = cmd_valid_q;
    assign grant_id_o  = grant_id_q;
    assign drop_o      = drop_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_traffic_cmd_scheduler.sv
// Bench for traffic_cmd_scheduler: directed steps plus a random phase, all
// checked cycle by cycle against a time-slot model of the scheduler.
module tb_traffic_cmd_scheduler;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int N   = 4;
    localparam int GAP = 2;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [N-1:0]       req_valid_i;
    logic [3*N-1:0]     req_type_i;
    logic [16*N-1:0]    req_data_i;
    logic [N-1:0]       req_ready_o;
    logic [2:0]         cmd_type_o;
    logic [15:0]        cmd_data_o;
    logic               cmd_valid_o;
    logic [2:0]         grant_id_o;
    logic               drop_o;
    logic               busy_o;

    always #5 clk_i = ~clk_i;

    traffic_cmd_scheduler #(
        .REQ_N(N), .GREEN_MS_DEF(16'd1000), .RED_MS_DEF(16'd1000),
        .YELLOW_MS_DEF(16'd300), .CMD_GAP(GAP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i),
        .req_type_i(req_type_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .cmd_type_o(cmd_type_o),
        .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o),
        .grant_id_o(grant_id_o), .drop_o(drop_o), .busy_o(busy_o)
    );

    // Requester-side stimulus
    bit          v[N];
    logic [2:0]  t[N];
    logic [15:0] d[N];
    bit          sticky;
    bit          rnd;

    always_comb begin
        req_valid_i = '0;
        req_type_i  = '0;
        req_data_i  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]        = v[i];
            req_type_i[3*i +: 3]  = t[i];
            req_data_i[16*i +: 16] = d[i];
        end
    end

    // Model: the scheduler looks at the bus only in "slots"; each command
    // occupies its slot plus GAP idle slots.
    int          e, next_sample, init_idx, ptr, granted;
    logic        exp_valid, exp_drop, exp_busy;
    logic [N-1:0] exp_ready;
    logic [2:0]  exp_type, exp_gid;
    logic [15:0] exp_data;
    logic [2:0]  init_t[4] = '{3'd3, 3'd4, 3'd5, 3'd0};
    logic [15:0] init_d[4] = '{16'd1000, 16'd1000, 16'd300, 16'd0};

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        next_sample = e;
        init_idx    = 0;
        ptr         = N - 1;
        granted     = -1;
        exp_valid   = 1'b0;
        exp_drop    = 1'b0;
        exp_busy    = 1'b1;
        exp_ready   = '0;
        exp_type    = 3'd0;
        exp_data    = 16'd0;
        exp_gid     = 3'd0;
    endtask

    task automatic model_issue(input int w);
        granted       = w;
        exp_ready[w]  = 1'b1;
        exp_gid       = 3'(w);
        if (t[w] >= 3'd6) begin
            exp_drop = 1'b1;
        end else begin
            exp_valid = 1'b1;
            exp_type  = t[w];
            exp_data  = d[w];
        end
    endtask

    task automatic model_edge();
        int w;
        exp_valid = 1'b0;
        exp_drop  = 1'b0;
        exp_ready = '0;
        granted   = -1;
        if (e == next_sample) begin
            next_sample = e + 1 + GAP;
            if (init_idx < 4) begin
                w = -1;
`ifdef TRAFFIC_CMD_PRIO_EN
                if (v[0] && t[0] == 3'd1) w = 0;
`endif
                if (w == 0) begin
                    model_issue(0);
                end else begin
                    exp_valid = 1'b1;
                    exp_type  = init_t[init_idx];
                    exp_data  = init_d[init_idx];
                    init_idx++;
                end
            end else begin
                w = -1;
`ifdef TRAFFIC_CMD_PRIO_EN
                if (v[0]) w = 0;
`endif
                for (int k = 1; k <= N && w < 0; k++) begin
                    if (v[(ptr + k) % N]) w = (ptr + k) % N;
                end
                if (w >= 0) begin
                    model_issue(w);
`ifdef TRAFFIC_CMD_PRIO_EN
                    if (w != 0) ptr = w;
`else
                    ptr = w;
`endif
                end else begin
                    next_sample = e + 1;
                end
            end
        end
        exp_busy = !(init_idx == 4 && next_sample == e + 1);
        e++;
    endtask

    task automatic check_all();
        check("cmd_valid", 32'(cmd_valid_o), 32'(exp_valid));
        check("cmd_type",  32'(cmd_type_o),  32'(exp_type));
        check("cmd_data",  32'(cmd_data_o),  32'(exp_data));
        check("req_ready", 32'(req_ready_o), 32'(exp_ready));
        check("grant_id",  32'(grant_id_o),  32'(exp_gid));
        check("drop",      32'(drop_o),      32'(exp_drop));
        check("busy",      32'(busy_o),      32'(exp_busy));
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_all();
        for (int i = 0; i < N; i++) begin
            if (granted == i && !sticky) v[i] = 1'b0;
        end
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        v[i] = 1'b1;
                        t[i] = 3'($urandom_range(0, 7));
                        d[i] = 16'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    v[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0;
            t[i] = 3'd0;
            d[i] = 16'd0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [2:0] gids[$];
        logic [2:0] exp_order[5];
        int         pulses;
        int         waited;

        e = 0;
        sticky = 1'b0;
        rnd = 1'b0;
        clear_reqs();
        model_reset();

        // Reset values while reset is held
        repeat (2) @(negedge clk_i);
        check_all();
        rst_i = 1'b0;
        model_reset();

        // Init sequence with no requests: (3,1000) (4,1000) (5,300) (0,0)
        cycle();
        check("init_first_type", 32'(cmd_type_o), 32'd3);
        check("init_first_data", 32'(cmd_data_o), 32'd1000);
        run(11);
        check("busy_after_init", 32'(busy_o), 32'd0);

        // Single request from requester 2
        v[2] = 1'b1; t[2] = 3'd4; d[2] = 16'd500;
        cycle();
        check("dir_ready", 32'(req_ready_o), 32'b0100);
        check("dir_valid", 32'(cmd_valid_o), 32'd1);
        check("dir_type",  32'(cmd_type_o),  32'd4);
        check("dir_data",  32'(cmd_data_o),  32'd500);
        check("dir_gid",   32'(grant_id_o),  32'd2);
        run(3);

        // Requester 3 alone moves the pointer to 3
        v[3] = 1'b1; t[3] = 3'd0; d[3] = 16'd123;
        run(4);

        // All requesters held valid continuously
        sticky = 1'b1;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; t[i] = 3'(i + 1); d[i] = 16'(100 + i);
        end
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            cycle();
            if (cmd_valid_o) begin
                pulses++;
                gids.push_back(grant_id_o);
            end
        end
`ifdef TRAFFIC_CMD_PRIO_EN
        exp_order = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
        exp_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
`endif
        check("rr_pulses", 32'(pulses), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("rr_order", (k < gids.size()) ? 32'(gids[k]) : 32'hFFFF, 32'(exp_order[k]));
        end
        sticky = 1'b0;
        clear_reqs();
        run(3);

        // Illegal type from requester 1 is dropped
        v[1] = 1'b1; t[1] = 3'd7; d[1] = 16'hBEEF;
        cycle();
        check("drop_pulse", 32'(drop_o),      32'd1);
        check("drop_ready", 32'(req_ready_o), 32'b0010);
        check("drop_valid", 32'(cmd_valid_o), 32'd0);
        check("drop_gid",   32'(grant_id_o),  32'd1);
        run(3);

        // Pointer to 2, then requesters 0 and 3 together
        v[2] = 1'b1; t[2] = 3'd2; d[2] = 16'd7;
        run(4);
        v[0] = 1'b1; t[0] = 3'd2; d[0] = 16'd11;
        v[3] = 1'b1; t[3] = 3'd2; d[3] = 16'd33;
        cycle();
`ifdef TRAFFIC_CMD_PRIO_EN
        check("prio_gid", 32'(grant_id_o), 32'd0);
`else
        check("prio_gid", 32'(grant_id_o), 32'd3);
`endif
        clear_reqs();
        run(4);

        // Random traffic
        rnd = 1'b1;
        run(400);
        rnd = 1'b0;
        clear_reqs();
        run(4);

        // Async reset during a gap at an arbitrary phase
        v[1] = 1'b1; t[1] = 3'd2; d[1] = 16'd42;
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (granted < 0 && waited < 10);
        check("rst_grant_seen", 32'(granted), 32'd1);
        clear_reqs();
        #($urandom_range(1, 3));
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge clk_i);
        check_all();
        rst_i = 1'b0;
        model_reset();
        cycle();
        check("reinit_type", 32'(cmd_type_o), 32'd3);
        check("reinit_data", 32'(cmd_data_o), 32'd1000);
        run(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
